trace_trigger_sequencer: RTL and testbench
==========================================

Name: trace_trigger_sequencer

Overview:
- Sits between the per-rule trace pattern matchers and the trig_out pin in the trace sniffer.
- Arms on a register-interface command, timestamps matches from enabled rules relative to arm, and drives trig_out in pulse or toggle mode.
- Logs each (rule, timestamp) event into a show-ahead FIFO that the USB register block drains.
- Single-shot or continuous operation, per REG_CAPTURE_MODE.

Parameters:
- pRULES, 8, number of match rules; rule id fits in 8 bits.
- pTS_WIDTH, 56, timestamp counter width.
- pFIFO_DEPTH, 16, event FIFO entries; power of two.
- pPULSE_CYCLES, 4, trig_out high time in pulse mode, in trace_clk cycles; must be 1..255.

Ports:
- trace_clk  in  1  sole clock.
- resetn  in  1  reset, asynchronous, active-low.
- I_match  in  pRULES  per-rule match strobe, one cycle per match.
- I_rule_enable  in  pRULES  REG_PATTERN_ENABLE; matches from disabled rules are ignored completely.
- I_trig_enable  in  pRULES  REG_PATTERN_TRIG_ENABLE; enabled rules that are also set here cause a trigger.
- I_trig_toggle  in  1  REG_TRIG_TOGGLE; 1 = toggle mode, 0 = pulse mode.
- I_capture_mode  in  1  1 = continuous, 0 = single trigger then DONE.
- I_arm  in  1  one-cycle arm strobe (REG_ARM write).
- I_disarm  in  1  one-cycle disarm strobe.
- I_fifo_rd  in  1  pop strobe.
- I_clear_overflow  in  1  clears O_fifo_overflow.
- O_trig_out  out  1  trigger output.
- O_armed  out  1  high in ARMED.
- O_state  out  2  current state encoding.
- O_fifo_data  out  8+pTS_WIDTH  {rule_id, timestamp}; valid when !O_fifo_empty.
- O_fifo_empty  out  1  FIFO empty flag.
- O_fifo_overflow  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset values:
  - state IDLE (0)
  - O_trig_out 0, O_armed 0, O_fifo_data 0, O_fifo_empty 1, O_fifo_overflow 0
  - timestamp 0, pulse counter 0
- States:
  - IDLE=0: I_arm -> ARMED.
  - ARMED=1: in single mode, first trigger -> DONE. I_disarm -> IDLE.
  - DONE=2: I_arm -> ARMED; I_disarm -> IDLE.
  - I_arm in ARMED re-arms, restarting the timestamp.
  - I_arm and I_disarm in the same cycle: disarm wins.
- Timestamp:
  - Loaded with 0 in the cycle I_arm is sampled.
  - Increments every cycle while ARMED.
  - Saturates at all-ones, no wrap.
  - Holds its value in IDLE and DONE.
- Event, registered (one-cycle latency):
  - hit = I_match & I_rule_enable, while in ARMED.
  - If hit != 0: push {lowest set index of hit, timestamp as of the match cycle}.
  - Only one push per cycle; other simultaneous hits are not logged.
- Trigger:
  - Fires when (hit & I_trig_enable) != 0.
  - O_trig_out responds one cycle after the match cycle.
  - Pulse mode: trig_out=1 for pPULSE_CYCLES cycles. A new trigger during a pulse reloads the counter, extending the pulse.
  - Toggle mode: trig_out inverts once per trigger cycle.
  - Changing I_trig_toggle mid-pulse: current level holds, and the new mode applies from the next trigger.
- Disarm or re-arm never truncates an in-flight pulse.
- FIFO:
  - Show-ahead; a pop with empty is ignored.
  - Push when full and no pop: event dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed.
  - Overflow set and clear in the same cycle: set wins.
  - Arm does not flush the FIFO.
- An asynchronous reset mid-pulse or mid-operation returns every output to its reset value immediately.

Optional Feature:
- Macro: TRACE_SOFT_TRIG_EN.
- When defined, ports I_soft_trig (1) and I_soft_trig_enable (1) exist.
  - I_soft_trig && I_soft_trig_enable in ARMED is treated as a trigger-enabled hit with rule_id 8'hFF.
  - The soft event is logged only when no rule hit occurs that cycle.
- When undefined, these ports and all their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package trace_seq_pkg holds:
  - state encodings ST_IDLE/ST_ARMED/ST_DONE
  - RULE_ID_W=8
  - SOFT_RULE_ID=8'hFF
  - event record width function
- Sub-module trace_event_fifo: synchronous show-ahead FIFO, parameterised width/depth, with full/empty flags and push-while-full-with-pop support.

Test Plan:
- Arm, then match rule 1 at 10 cycles after arm with enable=8'hFF, trig_enable=8'h02, pulse mode -> trig_out high for 4 cycles starting 1 cycle later; FIFO holds {8'h01, 56'd10}.
- Rules 3 and 5 match in the same cycle, trig_enable=8'h00 -> no trigger; exactly one entry is logged, with rule 3.
- Toggle mode, three triggers 5 cycles apart -> trig_out goes 1, 0, 1; three FIFO entries.
- Single mode (capture_mode=0), two enabled matches -> one trigger, state DONE, second match not logged; re-arm restarts the timestamp at 0.
- Fill 16 entries, push a 17th -> overflow=1 and the oldest entry is intact. Then push and pop in the same cycle while full -> count stays 16. Then assert I_clear_overflow -> overflow returns to 0.
- Assert resetn low for 1 cycle during a pulse -> trig_out=0, state IDLE, empty=1 asynchronously.

Source files
------------

// File: rtl/trace_seq_pkg.sv
// Shared definitions for the trace trigger sequencer.
//   state_e      : sequencer state encodings (IDLE/ARMED/DONE)
//   RULE_ID_W    : width of the rule id field in an event record
//   SOFT_RULE_ID : rule id logged for software-generated triggers
//   evt_width()  : width of one {rule_id, timestamp} event record
package trace_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int RULE_ID_W = 8;
  localparam logic [RULE_ID_W-1:0] SOFT_RULE_ID = 8'hFF;

  function automatic int evt_width(input int ts_width);
    return RULE_ID_W + ts_width;
  endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// Synchronous show-ahead FIFO for trace events.
//   trace_clk/resetn : clock, async active-low reset
//   push/push_data   : write strobe and data
//   pop              : read strobe (ignored while empty)
//   rd_data          : head entry, zero while empty
//   empty/full       : occupancy flags
//   drop             : push rejected because full with no pop this cycle
// A push while full succeeds when a pop happens in the same cycle.
module trace_event_fifo
  import trace_seq_pkg::*;
#(
  parameter int pWIDTH = 64,
  parameter int pDEPTH = 16
) (
  input  logic              trace_clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [pWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [pWIDTH-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              drop
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic wr_en, rd_en;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    drop     = push & full & ~rd_en;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge trace_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trace_trigger_sequencer.sv
// Trace trigger sequencer: arms on command, timestamps enabled rule matches
// relative to arm, drives trig_out (pulse or toggle) and logs events to a
// show-ahead FIFO drained by the register block.
//   trace_clk, resetn          : clock, async active-low reset
//   I_match                    : per-rule match strobes
//   I_rule_enable/I_trig_enable: rule logging / trigger masks
//   I_trig_toggle              : 1 toggle mode, 0 pulse mode
//   I_capture_mode             : 1 continuous, 0 single shot
//   I_arm/I_disarm             : command strobes (disarm wins)
//   I_fifo_rd/I_clear_overflow : FIFO pop / sticky overflow clear
//   O_trig_out, O_armed, O_state, O_fifo_data/empty/overflow : status
// Optional TRACE_SOFT_TRIG_EN adds I_soft_trig/I_soft_trig_enable, a
// software trigger logged with rule id 8'hFF when no rule hits.
//
// state    | meaning
// IDLE  0  | waiting for arm, timestamp held
// ARMED 1  | timestamp running, matches logged and triggering
// DONE  2  | single-shot trigger seen, timestamp held
module trace_trigger_sequencer
  import trace_seq_pkg::*;
#(
  parameter int pRULES        = 8,
  parameter int pTS_WIDTH     = 56,
  parameter int pFIFO_DEPTH   = 16,
  parameter int pPULSE_CYCLES = 4
) (
  input  logic                              trace_clk,
  input  logic                              resetn,
  input  logic [pRULES-1:0]                 I_match,
  input  logic [pRULES-1:0]                 I_rule_enable,
  input  logic [pRULES-1:0]                 I_trig_enable,
  input  logic                              I_trig_toggle,
  input  logic                              I_capture_mode,
  input  logic                              I_arm,
  input  logic                              I_disarm,
  input  logic                              I_fifo_rd,
  input  logic                              I_clear_overflow,
`ifdef TRACE_SOFT_TRIG_EN
  input  logic                              I_soft_trig,
  input  logic                              I_soft_trig_enable,
`endif
  output logic                              O_trig_out,
  output logic                              O_armed,
  output logic [1:0]                        O_state,
  output logic [evt_width(pTS_WIDTH)-1:0]   O_fifo_data,
  output logic                              O_fifo_empty,
  output logic                              O_fifo_overflow
);

  localparam int EVT_W = evt_width(pTS_WIDTH);
  localparam logic [pTS_WIDTH-1:0] TS_ONE = {{(pTS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [7:0] PULSE_LOAD = 8'(pPULSE_CYCLES);

  state_e state_q, state_d;
  logic [pTS_WIDTH-1:0] ts_q, ts_d;
  logic [7:0] cnt_q, cnt_d;
  logic trig_q, trig_d;
  logic ovf_q, ovf_d;

  logic armed, arm_take;
  logic [pRULES-1:0] hit;
  logic [RULE_ID_W-1:0] hit_id, evt_id;
  logic trig_fire, evt_push;
  logic fifo_full, fifo_drop;

  assign armed    = (state_q == ST_ARMED);
  assign arm_take = I_arm & ~I_disarm;

  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (I_disarm)
      state_d = ST_IDLE;
    else if (I_arm)
      state_d = ST_ARMED;
    else if (armed && trig_fire && !I_capture_mode)
      state_d = ST_DONE;
  end

  always_comb begin
    O_armed = armed;
    O_state = state_q;
  end

  // Lowest-index hit wins the single FIFO slot for the cycle.
  always_comb begin
    hit    = armed ? (I_match & I_rule_enable) : '0;
    hit_id = '0;
    for (int i = pRULES - 1; i >= 0; i--) begin
      if (hit[i]) hit_id = RULE_ID_W'(i);
    end
    trig_fire = |(hit & I_trig_enable);
    evt_push  = |hit;
    evt_id    = hit_id;
`ifdef TRACE_SOFT_TRIG_EN
    if (armed && I_soft_trig && I_soft_trig_enable) begin
      trig_fire = 1'b1;
      evt_push  = 1'b1;
      if (~|hit) evt_id = SOFT_RULE_ID;
    end
`endif
  end

  always_comb begin
    ts_d = ts_q;
    if (arm_take)
      ts_d = '0;
    else if (armed && !(&ts_q))
      ts_d = ts_q + TS_ONE;
  end

  // Pulse counter runs independently of state so disarm/re-arm never cut a
  // pulse short; a mode change only takes effect on the next trigger.
  always_comb begin
    trig_d = trig_q;
    cnt_d  = cnt_q;
    if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) trig_d = 1'b0;
    end
    if (trig_fire) begin
      if (I_trig_toggle) begin
        trig_d = ~trig_q;
        cnt_d  = 8'd0;
      end else begin
        trig_d = 1'b1;
        cnt_d  = PULSE_LOAD;
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (I_clear_overflow) ovf_d = 1'b0;
    if (fifo_drop)        ovf_d = 1'b1;
  end

  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) begin
      ts_q   <= '0;
      cnt_q  <= '0;
      trig_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
      ovf_q  <= ovf_d;
    end
  end

  assign O_trig_out      = trig_q;
  assign O_fifo_overflow = ovf_q;

  trace_event_fifo #(
    .pWIDTH (EVT_W),
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .trace_clk (trace_clk),
    .resetn    (resetn),
    .push      (evt_push),
    .push_data ({evt_id, ts_q}),
    .pop       (I_fifo_rd),
    .rd_data   (O_fifo_data),
    .empty     (O_fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

endmodule

// File: tb/tb_trace_trigger_sequencer.sv
module tb_trace_trigger_sequencer;

  logic        trace_clk;
  logic        resetn;
  logic [7:0]  I_match, I_rule_enable, I_trig_enable;
  logic        I_trig_toggle, I_capture_mode, I_arm, I_disarm;
  logic        I_fifo_rd, I_clear_overflow;
`ifdef TRACE_SOFT_TRIG_EN
  logic        I_soft_trig, I_soft_trig_enable;
`endif
  logic        O_trig_out, O_armed, O_fifo_empty, O_fifo_overflow;
  logic [1:0]  O_state;
  logic [63:0] O_fifo_data;

  int n_checks = 0;
  int n_errors = 0;

  trace_trigger_sequencer dut (
    .trace_clk        (trace_clk),
    .resetn           (resetn),
    .I_match          (I_match),
    .I_rule_enable    (I_rule_enable),
    .I_trig_enable    (I_trig_enable),
    .I_trig_toggle    (I_trig_toggle),
    .I_capture_mode   (I_capture_mode),
    .I_arm            (I_arm),
    .I_disarm         (I_disarm),
    .I_fifo_rd        (I_fifo_rd),
    .I_clear_overflow (I_clear_overflow),
`ifdef TRACE_SOFT_TRIG_EN
    .I_soft_trig        (I_soft_trig),
    .I_soft_trig_enable (I_soft_trig_enable),
`endif
    .O_trig_out       (O_trig_out),
    .O_armed          (O_armed),
    .O_state          (O_state),
    .O_fifo_data      (O_fifo_data),
    .O_fifo_empty     (O_fifo_empty),
    .O_fifo_overflow  (O_fifo_overflow)
  );

  initial trace_clk = 1'b0;
  always #5 trace_clk = ~trace_clk;

  task automatic tick();
    @(posedge trace_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    I_match = '0; I_rule_enable = 8'hFF; I_trig_enable = 8'h02;
    I_trig_toggle = 1'b0; I_capture_mode = 1'b1;
    I_arm = 1'b0; I_disarm = 1'b0; I_fifo_rd = 1'b0; I_clear_overflow = 1'b0;
`ifdef TRACE_SOFT_TRIG_EN
    I_soft_trig = 1'b0; I_soft_trig_enable = 1'b0;
`endif
    tick(); tick();
    chk("rst_state", O_state, 0);
    chk("rst_trig", O_trig_out, 0);
    chk("rst_armed", O_armed, 0);
    chk("rst_data", O_fifo_data, 0);
    chk("rst_empty", O_fifo_empty, 1);
    chk("rst_ovf", O_fifo_overflow, 0);
    resetn = 1'b1;
    tick();

    // Pulse trigger on rule 1 at timestamp 10
    I_arm = 1; tick(); I_arm = 0;
    chk("arm_state", O_state, 1);
    chk("arm_armed", O_armed, 1);
    repeat (10) tick();
    I_match = 8'h02; tick(); I_match = 0;
    chk("p_trig0", O_trig_out, 1);
    chk("p_empty", O_fifo_empty, 0);
    chk("p_data", O_fifo_data, {8'h01, 56'd10});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p_trig_hi", O_trig_out, 1);
    end
    tick();
    chk("p_trig_end", O_trig_out, 0);
    I_fifo_rd = 1; tick(); I_fifo_rd = 0;
    chk("p_pop_empty", O_fifo_empty, 1);
    chk("p_pop_data", O_fifo_data, 0);

    // Simultaneous rules 3 and 5, no trigger enable
    I_trig_enable = 8'h00;
    I_arm = 1; tick(); I_arm = 0;
    I_match = 8'h28; tick(); I_match = 0;
    chk("m_trig", O_trig_out, 0);
    chk("m_data", O_fifo_data, {8'h03, 56'd0});
    I_fifo_rd = 1; tick(); I_fifo_rd = 0;
    chk("m_one_entry", O_fifo_empty, 1);

    // Disabled rule ignored completely
    I_rule_enable = 8'hFE; I_trig_enable = 8'h01;
    I_match = 8'h01; tick(); I_match = 0;
    chk("dis_empty", O_fifo_empty, 1);
    chk("dis_trig", O_trig_out, 0);
    I_rule_enable = 8'hFF;

    // Toggle mode, three triggers 5 cycles apart
    I_trig_enable = 8'hFF; I_trig_toggle = 1;
    I_arm = 1; tick(); I_arm = 0;
    I_match = 8'h01; tick(); I_match = 0;
    chk("t_trig1", O_trig_out, 1);
    repeat (4) tick();
    chk("t_hold1", O_trig_out, 1);
    I_match = 8'h01; tick(); I_match = 0;
    chk("t_trig2", O_trig_out, 0);
    repeat (4) tick();
    I_match = 8'h01; tick(); I_match = 0;
    chk("t_trig3", O_trig_out, 1);
    chk("t_e0", O_fifo_data, {8'h00, 56'd0});
    I_fifo_rd = 1; tick(); I_fifo_rd = 0;
    chk("t_e1", O_fifo_data, {8'h00, 56'd5});
    I_fifo_rd = 1; tick(); I_fifo_rd = 0;
    chk("t_e2", O_fifo_data, {8'h00, 56'd10});
    I_fifo_rd = 1; tick(); I_fifo_rd = 0;
    chk("t_empty", O_fifo_empty, 1);

    // Single-shot mode
    I_trig_toggle = 0; I_capture_mode = 0;
    I_arm = 1; tick(); I_arm = 0;
    tick(); tick();
    I_match = 8'h04; tick(); I_match = 0;
    chk("s_done", O_state, 2);
    chk("s_trig", O_trig_out, 1);
    tick();
    I_match = 8'h08; tick(); I_match = 0;
    chk("s_state2", O_state, 2);
    chk("s_data", O_fifo_data, {8'h02, 56'd2});
    I_fifo_rd = 1; tick(); I_fifo_rd = 0;
    chk("s_no_second", O_fifo_empty, 1);
    tick();
    chk("s_trig_end", O_trig_out, 0);
    I_arm = 1; tick(); I_arm = 0;
    chk("s_rearm", O_state, 1);
    I_match = 8'h01; tick(); I_match = 0;
    chk("s_rearm_done", O_state, 2);
    chk("s_rearm_ts", O_fifo_data, {8'h00, 56'd0});
    I_fifo_rd = 1; tick(); I_fifo_rd = 0;
    repeat (3) tick();
    chk("s_rearm_trig_end", O_trig_out, 0);

    // Arm and disarm together: disarm wins
    I_arm = 1; I_disarm = 1; tick(); I_arm = 0; I_disarm = 0;
    chk("ad_idle", O_state, 0);
    I_capture_mode = 1;

    // Pulse extension by a retrigger
    I_arm = 1; tick(); I_arm = 0;
    I_match = 8'h01; tick(); I_match = 0;
    tick(); tick();
    I_match = 8'h01; tick(); I_match = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ext_hi", O_trig_out, 1);
    end
    tick();
    chk("ext_end", O_trig_out, 0);

    // Disarm does not truncate a pulse
    I_arm = 1; tick(); I_arm = 0;
    I_match = 8'h01; tick(); I_match = 0;
    I_disarm = 1; tick(); I_disarm = 0;
    chk("da_idle", O_state, 0);
    chk("da_trig", O_trig_out, 1);
    tick(); tick();
    chk("da_trig_late", O_trig_out, 1);
    tick();
    chk("da_trig_end", O_trig_out, 0);
    I_fifo_rd = 1; repeat (4) tick(); I_fifo_rd = 0;
    chk("pop_empty_ign", O_fifo_empty, 1);
    chk("pop_empty_data", O_fifo_data, 0);

    // FIFO full / overflow
    I_trig_enable = 8'h00;
    I_arm = 1; tick(); I_arm = 0;
    I_match = 8'h01;
    repeat (16) tick();
    chk("f_full_ovf", O_fifo_overflow, 0);
    chk("f_head", O_fifo_data, {8'h00, 56'd0});
    tick();
    chk("f_ovf_set", O_fifo_overflow, 1);
    chk("f_oldest", O_fifo_data, {8'h00, 56'd0});
    I_fifo_rd = 1; tick(); I_fifo_rd = 0; I_match = 0;
    chk("f_pushpop_head", O_fifo_data, {8'h00, 56'd1});
    chk("f_pushpop_ovf", O_fifo_overflow, 1);
    I_clear_overflow = 1; tick(); I_clear_overflow = 0;
    chk("f_clear", O_fifo_overflow, 0);
    I_clear_overflow = 1; I_match = 8'h01; tick(); I_clear_overflow = 0; I_match = 0;
    chk("f_set_wins", O_fifo_overflow, 1);
    I_clear_overflow = 1; tick(); I_clear_overflow = 0;
    chk("f_clear2", O_fifo_overflow, 0);
    for (int i = 0; i < 16; i++) begin
      chk("f_drain", O_fifo_data, {8'h00, 56'(i < 15 ? i + 1 : 17)});
      I_fifo_rd = 1; tick();
    end
    I_fifo_rd = 0;
    chk("f_drained", O_fifo_empty, 1);

    // Async reset during a pulse
    I_trig_enable = 8'h01;
    I_match = 8'h01; tick(); I_match = 0;
    tick();
    chk("r_pre_trig", O_trig_out, 1);
    #2 resetn = 0;
    #1;
    chk("r_trig", O_trig_out, 0);
    chk("r_state", O_state, 0);
    chk("r_armed", O_armed, 0);
    chk("r_empty", O_fifo_empty, 1);
    chk("r_data", O_fifo_data, 0);
    #2 resetn = 1;
    tick();
    chk("r_after_state", O_state, 0);
    chk("r_after_trig", O_trig_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
